switch_capture_slave: RTL

- Avalon-MM responder for the HPS lightweight bridge. It debounces the board slide switches, captures per-bit edges into sticky flags, and raises a level interrupt.
- Replaces the plain switches input PIO. The HPS sits at the initiator end; this block is the responder end of the bus that reads switches.
- Sits inside the Platform Designer system, with sw_in wired to the top-level switch pins.

---
 rtl/switch_capture_slave.sv | 119 +++++++++++
 1 files changed

// File: rtl/switch_capture_slave.sv
// rtl/switch_capture_slave.sv - Avalon-MM switch responder with debounce, sticky edge flags and level irq
// Each switch bit is synchronized, debounced independently, and its qualified edges latch into W1C flags.
module switch_capture_slave #(
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_SW-1:0] sw_in,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SW-1:0]            sync1_q, sync2_q;
  logic [NUM_SW-1:0]            stable_q, stable_d;
  logic [NUM_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_SW-1:0]            edge_q, edge_d;
  logic [NUM_SW-1:0]            mask_q, mask_d;
  logic [NUM_SW-1:0]            rise_sel_q, rise_sel_d;
  logic [NUM_SW-1:0]            fall_sel_q, fall_sel_d;
  logic [31:0]                  readdata_q, readdata_d;
  logic                         irq_q, irq_d;

  logic [NUM_SW-1:0]            rise, fall, edge_set, edge_clr;
  logic [31:0]                  rd_mux;
  logic                         unused_wdata;

  assign unused_wdata = ^avs_writedata;

  // Counter only advances while s2 disagrees with stable; the terminal compare bounds it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NUM_SW; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign rise     = stable_d & ~stable_q;
  assign fall     = ~stable_d & stable_q;
  assign edge_set = (rise & rise_sel_q) | (fall & fall_sel_q);
  assign edge_clr = (avs_write && avs_address == 2'd1) ? avs_writedata[NUM_SW-1:0] : '0;

  // Set is ORed in after the clear so a coincident new edge is never lost.
  always_comb begin
    edge_d     = (edge_q & ~edge_clr) | edge_set;
    mask_d     = mask_q;
    rise_sel_d = rise_sel_q;
    fall_sel_d = fall_sel_q;
    if (avs_write && avs_address == 2'd2) begin
      mask_d = avs_writedata[NUM_SW-1:0];
    end
    if (avs_write && avs_address == 2'd3) begin
      rise_sel_d = avs_writedata[NUM_SW-1:0];
      fall_sel_d = avs_writedata[16 +: NUM_SW];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux[NUM_SW-1:0] = stable_q;
      2'd1: rd_mux[NUM_SW-1:0] = edge_q;
      2'd2: rd_mux[NUM_SW-1:0] = mask_q;
      default: begin
        rd_mux[NUM_SW-1:0]  = rise_sel_q;
        rd_mux[16 +: NUM_SW] = fall_sel_q;
      end
    endcase
  end

  assign readdata_d = avs_read ? rd_mux : readdata_q;
  assign irq_d      = |(edge_q & mask_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      rise_sel_q <= '0;
      fall_sel_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sw_in;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      rise_sel_q <= rise_sel_d;
      fall_sel_q <= fall_sel_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign avs_irq      = irq_q;

endmodule
